// File: rtl/collatz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : collatz_pkg
// Purpose  : Shared definitions for the collatz run controller: FSM state
//            encodings and the fixed burst-length width.
// Revision : 1.0 - initial release
// ============================================================================
package collatz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int unsigned c_burst_len_bits = 16;

endpackage
`default_nettype wire

// File: rtl/collatz_stall_mon.sv
`default_nettype none
// ============================================================================
// Module   : collatz_stall_mon
// Purpose  : Detects that the core's start value has stopped advancing.
//            On every enabled cycle start is compared with its value from the
//            previous enabled cycle; a run of equal compares is counted.
//            stall is combinational and fires in the enabled cycle whose
//            compare brings the run to stall_limit.
// Ports    : clk, reset - clock, synchronous active-high reset
//            en         - core enable for this cycle
//            clr        - zero the run counter
//            start      - core start value
//            stall      - run of equal compares reaches stall_limit now
// Revision : 1.0 - initial release
// ============================================================================
module collatz_stall_mon #(
  parameter int unsigned bits        = 160,
  parameter int unsigned stall_limit = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [bits-1:0] start,
  output logic            stall
);

  localparam int unsigned     c_cnt_w = $clog2(stall_limit + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(stall_limit - 1);
  localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(stall_limit);

  logic [bits-1:0]    r_prev;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_same;

  assign w_same = (start == r_prev);
  // The counter still holds limit-1 here; this compare completes the run.
  assign stall  = en & w_same & (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      if (en) begin
        r_prev <= start;
      end
      if (clr) begin
        r_cnt <= '0;
      end else if (en) begin
        if (!w_same) begin
          r_cnt <= '0;
        end else if (r_cnt != c_max) begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/collatz_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : collatz_run_ctrl
// Purpose  : Sequencer for the collatz_conjecture core and sole driver of its
//            clken. Free-run, single-step and N-step burst modes, saturating
//            count of enabled steps, automatic halt when the start value
//            stalls, and snap_req-edge-triggered snapshots of start/actual.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cmd_run             - level, free-run while high
//            cmd_step            - pulse, one enabled core cycle
//            cmd_burst/burst_len - pulse, burst_len enabled core cycles
//            cmd_clear           - pulse, leave HALT and clear counters
//            start, actual       - core values
//            snap_req            - rising edge requests a snapshot
//            clken               - registered core enable
//            snap_start/actual   - low snap_bits of start/actual
//            snap_valid          - 1-cycle pulse on snapshot update
//            steps               - saturating enabled-cycle count
//            burst_done          - 1-cycle pulse at end of a burst
//            stalled             - high while halted
//            state               - current FSM state
// Revision : 1.0 - initial release
// ============================================================================
module collatz_run_ctrl #(
  parameter int unsigned bits        = 160,
  parameter int unsigned snap_bits   = 128,
  parameter int unsigned cnt_bits    = 32,
  parameter int unsigned stall_limit = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_run,
  input  logic                 cmd_step,
  input  logic                 cmd_burst,
  input  logic                 cmd_clear,
  input  logic [15:0]          burst_len,
  input  logic [bits-1:0]      start,
  input  logic [bits-1:0]      actual,
  input  logic                 snap_req,
  output logic                 clken,
  output logic [snap_bits-1:0] snap_start,
  output logic [snap_bits-1:0] snap_actual,
  output logic                 snap_valid,
  output logic [cnt_bits-1:0]  steps,
  output logic                 burst_done,
  output logic                 stalled,
  output logic [1:0]           state
);

  import collatz_pkg::*;

  state_t                      r_state, w_state_n;
  logic                        r_clken, w_clken_n;
  logic [c_burst_len_bits-1:0] r_burst_cnt, w_burst_cnt_n;
  logic                        r_burst_done, w_burst_done_n;
  logic                        w_stall;
  logic                        w_clear;
  logic [cnt_bits-1:0]         r_steps;
  logic                        r_snap_req_d;
  logic                        r_snap_rise;
  logic [snap_bits-1:0]        r_snap_start;
  logic [snap_bits-1:0]        r_snap_actual;
  logic                        r_snap_valid;

  // A stall in the same cycle as cmd_clear wins; the clear is dropped.
  assign w_clear = cmd_clear & ~w_stall;

  collatz_stall_mon #(
    .bits        (bits),
    .stall_limit (stall_limit)
  ) u_stall_mon (
    .clk   (clk),
    .reset (reset),
    .en    (r_clken),
    .clr   (w_clear),
    .start (start),
    .stall (w_stall)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_clken      <= 1'b0;
      r_burst_cnt  <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_clken      <= w_clken_n;
      r_burst_cnt  <= w_burst_cnt_n;
      r_burst_done <= w_burst_done_n;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next registered outputs. clken is registered, so every
  // decision here takes effect on the core in the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n      = r_state;
    w_clken_n      = 1'b0;
    w_burst_cnt_n  = r_burst_cnt;
    w_burst_done_n = 1'b0;
    if (w_stall) begin
      w_state_n     = ST_HALT;
      w_burst_cnt_n = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_clear) begin
            // clear takes the cycle; other commands are dropped
          end else if (cmd_run) begin
            w_state_n = ST_RUN;
            w_clken_n = 1'b1;
          end else if (cmd_burst) begin
            if (burst_len != '0) begin
              w_state_n     = ST_BURST;
              w_clken_n     = 1'b1;
              w_burst_cnt_n = burst_len;
            end else begin
              w_burst_done_n = 1'b1;
            end
          end else if (cmd_step) begin
            w_clken_n = 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd_run) begin
            w_clken_n = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
          end
        end
        ST_BURST: begin
          // clken is high in every BURST cycle; the counter holds the number
          // of enabled cycles left including the current one.
          if (r_burst_cnt <= c_burst_len_bits'(1)) begin
            w_state_n      = ST_IDLE;
            w_burst_cnt_n  = '0;
            w_burst_done_n = 1'b1;
          end else begin
            w_clken_n     = 1'b1;
            w_burst_cnt_n = r_burst_cnt - c_burst_len_bits'(1);
          end
        end
        ST_HALT: begin
          if (cmd_clear) begin
            w_state_n = ST_IDLE;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating step counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_steps <= '0;
    end else if (w_clear) begin
      r_steps <= '0;
    end else if (r_clken && (r_steps != '1)) begin
      r_steps <= r_steps + cnt_bits'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Snapshot: edge detected in the cycle snap_req first reads high, values
  // captured one cycle later so the copy is taken from a settled core cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_req_d  <= 1'b0;
      r_snap_rise   <= 1'b0;
      r_snap_start  <= '0;
      r_snap_actual <= '0;
      r_snap_valid  <= 1'b0;
    end else begin
      r_snap_req_d <= snap_req;
      r_snap_rise  <= snap_req & ~r_snap_req_d;
      r_snap_valid <= r_snap_rise;
      if (r_snap_rise) begin
        r_snap_start  <= start[snap_bits-1:0];
        r_snap_actual <= actual[snap_bits-1:0];
      end
    end
  end

  // Upper bits of actual are not part of the snapshot.
  generate
    if (bits > snap_bits) begin : g_actual_hi
      logic w_unused_actual_hi;
      assign w_unused_actual_hi = ^actual[bits-1:snap_bits];
    end
  endgenerate

  assign clken       = r_clken;
  assign snap_start  = r_snap_start;
  assign snap_actual = r_snap_actual;
  assign snap_valid  = r_snap_valid;
  assign steps       = r_steps;
  assign burst_done  = r_burst_done;
  assign stalled     = (r_state == ST_HALT);
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_collatz_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_collatz_run_ctrl
// Purpose  : Self-checking bench for collatz_run_ctrl (table of single-cycle
//            command vectors plus directed multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_collatz_run_ctrl;

  localparam int BITS  = 160;
  localparam int SNAP  = 128;
  localparam int CNT   = 32;
  localparam int LIMIT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_run, cmd_step, cmd_burst, cmd_clear;
  logic [15:0]      burst_len;
  logic [BITS-1:0]  start, actual;
  logic             snap_req;
  logic             clken;
  logic [SNAP-1:0]  snap_start, snap_actual;
  logic             snap_valid;
  logic [CNT-1:0]   steps;
  logic             burst_done;
  logic             stalled;
  logic [1:0]       state;

  always #5 clk = ~clk;

  collatz_run_ctrl #(
    .bits        (BITS),
    .snap_bits   (SNAP),
    .cnt_bits    (CNT),
    .stall_limit (LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_run     (cmd_run),
    .cmd_step    (cmd_step),
    .cmd_burst   (cmd_burst),
    .cmd_clear   (cmd_clear),
    .burst_len   (burst_len),
    .start       (start),
    .actual      (actual),
    .snap_req    (snap_req),
    .clken       (clken),
    .snap_start  (snap_start),
    .snap_actual (snap_actual),
    .snap_valid  (snap_valid),
    .steps       (steps),
    .burst_done  (burst_done),
    .stalled     (stalled),
    .state       (state)
  );

  int nchk = 0;
  int nerr = 0;
  bit inc  = 1'b0;

  typedef struct {
    logic        run;
    logic        step;
    logic        burst;
    logic        clear;
    logic [15:0] len;
    logic        e_clken;
    logic        e_bdone;
    logic [1:0]  e_state;
    logic [31:0] e_steps;
  } vec_t;

  vec_t tbl [14];

  // One clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (inc) begin
      start  = start + 1'b1;
      actual = ~start;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int ones, bdn, bd_j, cnt_en, nval, rise_c, cap_c;
    logic [127:0] exp_s, exp_a;
    bit nr;

    // run step burst clear len        clken bdone state steps
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 2'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 32'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 1'b1, 1'b0, 2'd2, 32'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 2'd2, 32'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 2'd2, 32'd3};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 32'd4};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 32'd4};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 2'd0, 32'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 32'd4};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 1'b0, 2'd1, 32'd4};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 2'd1, 32'd5};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 32'd6};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 32'd6};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 2'd0, 32'd0};

    reset = 1'b1; cmd_run = 1'b0; cmd_step = 1'b0; cmd_burst = 1'b0; cmd_clear = 1'b0;
    burst_len = '0; start = '0; actual = '0; snap_req = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_clken", 128'(clken), 128'(0));
    chk("rst_steps", 128'(steps), 128'(0));
    chk("rst_snap_valid", 128'(snap_valid), 128'(0));
    chk("rst_stalled", 128'(stalled), 128'(0));
    chk("rst_snap_start", snap_start, 128'(0));
    reset = 1'b0;
    repeat (7) tick();

    // Single-cycle command vectors: step, short burst, zero burst, run/burst race, clear
    for (int i = 0; i < 14; i++) begin
      cmd_run = tbl[i].run; cmd_step = tbl[i].step; cmd_burst = tbl[i].burst;
      cmd_clear = tbl[i].clear; burst_len = tbl[i].len;
      tick();
      chk($sformatf("row%0d_clken", i), 128'(clken), 128'(tbl[i].e_clken));
      chk($sformatf("row%0d_burst_done", i), 128'(burst_done), 128'(tbl[i].e_bdone));
      chk($sformatf("row%0d_state", i), 128'(state), 128'(tbl[i].e_state));
      chk($sformatf("row%0d_steps", i), 128'(steps), 128'(tbl[i].e_steps));
    end
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_burst = 1'b0; cmd_clear = 1'b0; burst_len = '0;

    // Burst of 5 with a step pulse inside it
    cmd_burst = 1'b1; burst_len = 16'd5;
    tick();
    cmd_burst = 1'b0; burst_len = '0;
    ones = clken ? 1 : 0; bdn = 0; bd_j = -1;
    for (int j = 0; j < 10; j++) begin
      cmd_step = (j == 0);
      tick();
      cmd_step = 1'b0;
      if (clken) ones++;
      if (burst_done) begin
        bdn++;
        bd_j = j;
        chk("burst_done_clken", 128'(clken), 128'(0));
      end
    end
    chk("burst5_clken_cycles", 128'(ones), 128'(5));
    chk("burst5_done_pulses", 128'(bdn), 128'(1));
    chk("burst5_done_cycle", 128'(bd_j), 128'(4));
    chk("burst5_steps", 128'(steps), 128'(5));

    // Free-run 100 cycles with an advancing start value
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    inc = 1'b1; cmd_run = 1'b1;
    repeat (100) tick();
    cmd_run = 1'b0; inc = 1'b0;
    repeat (3) tick();
    chk("run100_steps", 128'(steps), 128'(100));
    chk("run100_state", 128'(state), 128'(0));
    chk("run100_stalled", 128'(stalled), 128'(0));

    // Held start value: halt after LIMIT enabled cycles
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    chk("clear_steps", 128'(steps), 128'(0));
    cmd_run = 1'b1; cnt_en = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stalled) break;
      if (clken) cnt_en++;
    end
    chk("stall_enabled_cycles", 128'(cnt_en), 128'(LIMIT));
    chk("stall_stalled", 128'(stalled), 128'(1));
    chk("stall_clken", 128'(clken), 128'(0));
    chk("stall_state", 128'(state), 128'(3));
    chk("stall_steps", 128'(steps), 128'(LIMIT));
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    repeat (2) tick();
    chk("halt_hold_state", 128'(state), 128'(3));
    chk("halt_hold_clken", 128'(clken), 128'(0));
    cmd_run = 1'b0;
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    chk("halt_clear_state", 128'(state), 128'(0));
    chk("halt_clear_stalled", 128'(stalled), 128'(0));
    chk("halt_clear_steps", 128'(steps), 128'(0));

    // Snapshots while running: snap_req toggles every 50 cycles
    inc = 1'b1; actual = ~start; cmd_run = 1'b1;
    nval = 0; rise_c = -10; cap_c = -10; exp_s = '0; exp_a = '0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (snap_valid) begin
        nval++;
        chk("snap_start", snap_start, exp_s);
        chk("snap_actual", snap_actual, exp_a);
        chk("snap_cycle", 128'(c), 128'(cap_c + 1));
      end
      if (c == rise_c + 1) begin
        exp_s = start[127:0];
        exp_a = actual[127:0];
        cap_c = c;
      end
      nr = ((c / 50) % 2) == 1;
      if (nr && !snap_req) rise_c = c;
      snap_req = nr;
    end
    snap_req = 1'b0; cmd_run = 1'b0;
    repeat (3) tick();
    chk("snap_pulse_count", 128'(nval), 128'(2));
    chk("snap_run_stalled", 128'(stalled), 128'(0));

    // Reset in the middle of a long burst
    cmd_burst = 1'b1; burst_len = 16'd1000; tick(); cmd_burst = 1'b0; burst_len = '0;
    repeat (20) tick();
    chk("longburst_state", 128'(state), 128'(2));
    chk("longburst_clken", 128'(clken), 128'(1));
    reset = 1'b1; tick();
    chk("midrst_clken", 128'(clken), 128'(0));
    chk("midrst_state", 128'(state), 128'(0));
    chk("midrst_steps", 128'(steps), 128'(0));
    chk("midrst_burst_done", 128'(burst_done), 128'(0));
    chk("midrst_stalled", 128'(stalled), 128'(0));
    chk("midrst_snap_start", snap_start, 128'(0));
    chk("midrst_snap_actual", snap_actual, 128'(0));
    chk("midrst_snap_valid", 128'(snap_valid), 128'(0));
    reset = 1'b0; tick();
    chk("post_rst_clken", 128'(clken), 128'(0));

    // Run and burst together: run wins
    cmd_run = 1'b1; cmd_burst = 1'b1; burst_len = 16'd7;
    tick();
    cmd_burst = 1'b0; burst_len = '0;
    chk("race_state", 128'(state), 128'(1));
    chk("race_clken", 128'(clken), 128'(1));
    cmd_run = 1'b0;
    repeat (2) tick();
    chk("race_end_state", 128'(state), 128'(0));
    chk("race_end_clken", 128'(clken), 128'(0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
